cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller that sits between the CPU's instruction/data cache arrays and the shared multi-cycle main memory. On a cache miss it captures the block base address, issues one read request per cycle for every word of the block, counts returned words, and drives data-array and tag-array write strobes so the cache is refilled in place. The CPU pipeline stalls on `fsm_busy` until the fill completes.

## Interface

Parameters:
- `BLOCK_WORDS`, 8: 16-bit words per cache block; power of two, 2..16.
- `AWIDTH`, 16: byte-address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `miss_detected`  in  1  cache reports a miss this cycle.
- `miss_address`  in  AWIDTH  byte address of the missing access.
- `memory_data_valid`  in  1  main memory returns one word this cycle, in request order.
- `fsm_busy`  out  1  fill in progress; CPU stall.
- `memory_read_en`  out  1  read request to main memory this cycle.
- `memory_address`  out  AWIDTH  byte address of the current request.
- `write_data_array`  out  1  write returned word into data array this cycle.
- `word_offset`  out  log2(BLOCK_WORDS)  word index within block for `write_data_array`.
- `write_tag_array`  out  1  write tag/valid for the block this cycle.
- `fill_done`  out  1  one-cycle pulse, fill complete.

## Operation

- States: IDLE, FILL.
- Registers: `base_addr` (AWIDTH), `issue_cnt` and `recv_cnt` (log2(BLOCK_WORDS)+1 bits each), state.
- IDLE: `miss_detected`=1 -> capture `base_addr = miss_address` with low log2(2*BLOCK_WORDS) bits cleared (BLOCK_WORDS=8: low 4 bits); clear both counters; -> FILL.
- FILL request side: while `issue_cnt < BLOCK_WORDS`, `memory_read_en`=1, `memory_address = base_addr + 2*issue_cnt` (AWIDTH-bit add, no carry out; base alignment guarantees no wrap); `issue_cnt` increments each cycle. At `issue_cnt == BLOCK_WORDS`, `memory_read_en`=0, `memory_address`=0.
- FILL response side: each cycle with `memory_data_valid`=1: `write_data_array`=1, `word_offset = recv_cnt[low bits]`, `recv_cnt` increments. Combinational from `memory_data_valid` and `recv_cnt`.
- Last word (`memory_data_valid`=1 and `recv_cnt == BLOCK_WORDS-1`): `write_data_array`, `write_tag_array`, `fill_done` all 1 in that same cycle; next state IDLE.
- Outputs in IDLE: all 0 (`memory_address`=0, `word_offset`=0).
- `fsm_busy` = (state == FILL), registered state decode.
- Block does not depend on memory latency; only counts `memory_data_valid`.

Boundary rules:
- `miss_detected` while FILL: ignored; `miss_address` not re-captured.
- `memory_data_valid` in IDLE: ignored, no strobes.
- Valid arriving in the same cycle as a request: both handled; counters independent.
- Back-to-back miss: `miss_detected` in the first IDLE cycle after a fill starts a new fill immediately.
- `rst`=0 at any time, including mid-FILL: next edge -> IDLE, counters 0, `base_addr` 0; in-flight requests abandoned. Memory is reset by the same `rst`, so no stale returns.

## Timing

- Reset values: all outputs 0; state IDLE.
- Cycle 0: `miss_detected`=1 in IDLE. Cycle 1: `fsm_busy`=1, first request at base.
- Requests in cycles 1..BLOCK_WORDS, one per cycle, no gaps.
- With memory latency L (valid L cycles after request), words return in cycles 1+L..BLOCK_WORDS+L; tag write and `fill_done` in cycle BLOCK_WORDS+L; `fsm_busy`=0 from cycle BLOCK_WORDS+L+1.
- Default config, L=4: stall window 12 cycles (cycles 1..12).

## Test plan

- Reset: hold `rst`=0 three cycles with `miss_detected`=1, `memory_data_valid`=1 -> all outputs 0 throughout, state IDLE after release.
- Basic fill, L=4: miss at 0x1236 -> requests 0x1230,0x1232,...,0x123E in cycles 1..8; `write_data_array` cycles 5..12 with `word_offset` 0..7; `write_tag_array`=`fill_done`=1 only in cycle 12; `fsm_busy` 1 in cycles 1..12.
- Irregular returns: memory inserts 2-cycle gaps between valids -> `word_offset` still 0..7 in order, tag write on 8th valid only, no extra requests after 8.
- Ignored inputs: pulse `miss_detected` with 0xABCD mid-fill and `memory_data_valid` while IDLE -> addresses unchanged, no strobes in IDLE.
- Reset mid-fill: assert `rst`=0 after 3rd returned word -> next cycle all outputs 0; new miss at 0xFFF2 then fills 0xFFF0..0xFFFE with no address wrap.
- Back-to-back: miss at 0x0040 asserted in first IDLE cycle after a fill -> new request to 0x0040 the following cycle.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, streams one read per cycle for every word
// of the aligned block, counts returned words and strobes the data/tag arrays.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int AWIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [AWIDTH-1:0]              miss_address,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           memory_read_en,
    output logic [AWIDTH-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_offset,
    output logic                           write_tag_array,
    output logic                           fill_done
);

    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int CW = OW + 1;
    // Byte alignment of a block: BLOCK_WORDS 16-bit words span 2*BLOCK_WORDS bytes.
    localparam int AL = OW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] base_addr, base_nxt;
    logic [CW-1:0]     issue_cnt, issue_nxt;
    logic [CW-1:0]     recv_cnt, recv_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            base_addr <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            base_addr <= base_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
        end
    end

    assign fsm_busy = (state == FILL);

    always_comb begin
        state_nxt        = state;
        base_nxt         = base_addr;
        issue_nxt        = issue_cnt;
        recv_nxt         = recv_cnt;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_offset      = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_nxt  = {miss_address[AWIDTH-1:AL], {AL{1'b0}}};
                    issue_nxt = '0;
                    recv_nxt  = '0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                // Request and response sides run independently; memory latency is never assumed.
                if (issue_cnt < CW'(BLOCK_WORDS)) begin
                    memory_read_en = 1'b1;
                    memory_address = base_addr + AWIDTH'({issue_cnt, 1'b0});
                    issue_nxt      = issue_cnt + CW'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_offset      = recv_cnt[OW-1:0];
                    recv_nxt         = recv_cnt + CW'(1);
                    if (recv_cnt == CW'(BLOCK_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: vector table for the basic and back-to-back
// fills, plus hand-written sequences for gapped returns and reset mid-fill.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic        write_tag_array;
    logic        fill_done;

    int n_cmp = 0;
    int n_bad = 0;

    cache_fill_fsm #(.BLOCK_WORDS(8), .AWIDTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_offset       (word_offset),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        mdv;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wda;
        logic [2:0]  off;
        logic        tag;
        logic        done;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic miss, logic [15:0] maddr, logic mdv, logic busy,
                                logic rd, logic [15:0] addr, logic wda, logic [2:0] off,
                                logic tag, logic done);
        vec_t v;
        v.miss = miss; v.maddr = maddr; v.mdv = mdv; v.busy = busy; v.rd = rd;
        v.addr = addr; v.wda = wda; v.off = off; v.tag = tag; v.done = done;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic busy, input logic rd,
                           input logic [15:0] addr, input logic wda, input logic [2:0] off,
                           input logic tag, input logic done);
        chk({nm, ".busy"}, int'(fsm_busy), int'(busy));
        chk({nm, ".rd"},   int'(memory_read_en), int'(rd));
        chk({nm, ".addr"}, int'(memory_address), int'(addr));
        chk({nm, ".wda"},  int'(write_data_array), int'(wda));
        chk({nm, ".off"},  int'(word_offset), int'(off));
        chk({nm, ".tag"},  int'(write_tag_array), int'(tag));
        chk({nm, ".done"}, int'(fill_done), int'(done));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Miss in cycle 0; the 8 valids arrive at cycles first, first+gap+1, ...
    task automatic run_fill(input logic [15:0] ma, input logic [15:0] base,
                            input int first, input int gap, input string nm);
        int last;
        int nvalid;
        int nreads;
        logic busy_e, rd_e, wda_e;
        logic [15:0] addr_e;
        last   = first + 7 * (gap + 1);
        nvalid = 0;
        nreads = 0;
        for (int c = 0; c <= last + 1; c++) begin
            miss_detected     = (c == 0);
            miss_address      = ma;
            memory_data_valid = (c >= first && c <= last && ((c - first) % (gap + 1)) == 0);
            @(negedge clk);
            busy_e = (c >= 1 && c <= last);
            rd_e   = (c >= 1 && c <= 8);
            addr_e = rd_e ? base + 16'(2 * (c - 1)) : 16'h0000;
            wda_e  = memory_data_valid && busy_e;
            chk_out($sformatf("%s[%0d]", nm, c), busy_e, rd_e, addr_e, wda_e,
                    wda_e ? 3'(nvalid) : 3'd0, wda_e && nvalid == 7, wda_e && nvalid == 7);
            if (memory_read_en) nreads++;
            if (wda_e) nvalid++;
            next_cycle();
        end
        chk({nm, ".nreads"}, nreads, 8);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1, 16'h1236, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 0, 1, 1, 16'h1230, 0, 0, 0, 0);
        tbl[2]  = mk(0, 16'h0000, 0, 1, 1, 16'h1232, 0, 0, 0, 0);
        tbl[3]  = mk(0, 16'h0000, 0, 1, 1, 16'h1234, 0, 0, 0, 0);
        tbl[4]  = mk(0, 16'h0000, 0, 1, 1, 16'h1236, 0, 0, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 1, 1, 1, 16'h1238, 1, 0, 0, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 1, 16'h123A, 1, 1, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 1, 16'h123C, 1, 2, 0, 0);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 1, 16'h123E, 1, 3, 0, 0);
        tbl[9]  = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 4, 0, 0);
        tbl[10] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 5, 0, 0);
        tbl[11] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 6, 0, 0);
        tbl[12] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 7, 1, 1);
        tbl[13] = mk(1, 16'h0040, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[14] = mk(0, 16'h0000, 1, 1, 1, 16'h0040, 1, 0, 0, 0);
        tbl[15] = mk(0, 16'h0000, 1, 1, 1, 16'h0042, 1, 1, 0, 0);
        tbl[16] = mk(1, 16'hABCD, 1, 1, 1, 16'h0044, 1, 2, 0, 0);
        tbl[17] = mk(0, 16'h0000, 1, 1, 1, 16'h0046, 1, 3, 0, 0);
        tbl[18] = mk(0, 16'h0000, 1, 1, 1, 16'h0048, 1, 4, 0, 0);
        tbl[19] = mk(0, 16'h0000, 1, 1, 1, 16'h004A, 1, 5, 0, 0);
        tbl[20] = mk(0, 16'h0000, 1, 1, 1, 16'h004C, 1, 6, 0, 0);
        tbl[21] = mk(0, 16'h0000, 1, 1, 1, 16'h004E, 1, 7, 1, 1);
        tbl[22] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[23] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

        // Reset held with misses and returns pending.
        rst               = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out($sformatf("reset[%0d]", i), 0, 0, 16'h0000, 0, 0, 0, 0);
            next_cycle();
        end
        rst               = 1'b1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        @(negedge clk);
        chk_out("post_reset", 0, 0, 16'h0000, 0, 0, 0, 0);
        next_cycle();

        // Basic fill (L=4), back-to-back fill with same-cycle returns, ignored inputs.
        for (int i = 0; i < 24; i++) begin
            miss_detected     = tbl[i].miss;
            miss_address      = tbl[i].maddr;
            memory_data_valid = tbl[i].mdv;
            @(negedge clk);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].busy, tbl[i].rd, tbl[i].addr,
                    tbl[i].wda, tbl[i].off, tbl[i].tag, tbl[i].done);
            next_cycle();
        end

        // Returns separated by 2-cycle gaps.
        run_fill(16'h2009, 16'h2000, 2, 2, "gaps");

        // Reset after the third returned word of a fill (L=1).
        for (int c = 0; c <= 4; c++) begin
            miss_detected     = (c == 0);
            miss_address      = 16'h5555;
            memory_data_valid = (c >= 2);
            @(negedge clk);
            if (c == 0)
                chk_out("midrst[0]", 0, 0, 16'h0000, 0, 0, 0, 0);
            else
                chk_out($sformatf("midrst[%0d]", c), 1, 1, 16'h5550 + 16'(2 * (c - 1)),
                        c >= 2, (c >= 2) ? 3'(c - 2) : 3'd0, 0, 0);
            next_cycle();
        end
        rst               = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        next_cycle();
        rst               = 1'b1;
        memory_data_valid = 1'b0;
        @(negedge clk);
        chk_out("midrst_after", 0, 0, 16'h0000, 0, 0, 0, 0);
        next_cycle();

        // Top-of-memory block: no address wrap, counters restarted by the reset.
        run_fill(16'hFFF2, 16'hFFF0, 4, 0, "top");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
